// File: rtl/ram_fsm_pkg.sv
// Shared state encoding, status LED bit positions and the fill pattern for the RAM sequencer.
package ram_fsm_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StWrite = 3'd1;
   localparam state_t StRead  = 3'd2;
   localparam state_t StCheck = 3'd3;
   localparam state_t StHold  = 3'd4;
   localparam state_t StDone  = 3'd5;

   localparam int LedWrite = 0;
   localparam int LedRead  = 1;
   localparam int LedDone  = 2;
   localparam int LedErr   = 3;

   // Callers truncate the result to their data width.
   function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
      return addr ^ seed;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Hold-time prescaler: counts enabled cycles and pulses tick on the last one of each period.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clock,
   input  logic i_reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = enable && (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ram_seq_ctrl.sv
// RAM fill/verify sequencer: writes a seeded pattern to every word, then reads each word back,
// shows its low nibble on the LEDs for a hold period and counts mismatches.
module ram_seq_ctrl
   import ram_fsm_pkg::*;
#(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 8,
   parameter logic [31:0] SEED     = 32'h0000_00A5,
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_enable,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic [3:0]        o_leds,
   output logic [3:0]        o_led_r,
   output logic              o_done,
   output logic [ADDR_W:0]   o_err_cnt
);

   localparam int unsigned ErrW = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LastAddr = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [3:0]        leds_q, leds_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
   logic [DATA_W-1:0] pat;
   logic              tick;

   assign pat = DATA_W'(pattern(32'(cnt_q), SEED));

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clock   (clock),
      .i_reset (i_reset),
      .clear   (state_q == StCheck),
      .enable  ((state_q == StHold) && i_enable),
      .tick    (tick)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      leds_d    = leds_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         StIdle: begin
            if (i_enable) begin
               state_d   = StWrite;
               cnt_d     = '0;
               err_d     = 1'b0;
               err_cnt_d = '0;
            end
         end
         StWrite: begin
            if (i_enable) begin
               if (cnt_q == LastAddr) begin
                  state_d = StRead;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         StRead:  state_d = StCheck;
         StCheck: begin
            // Read data for cnt_q arrives this cycle; i_enable is deliberately ignored.
            leds_d  = i_ram_rdata[3:0];
            state_d = StHold;
            if (i_ram_rdata != pat) begin
               err_d     = 1'b1;
               err_cnt_d = err_cnt_q + ErrW'(1);
            end
         end
         StHold: begin
            if (tick) begin
               if (cnt_q == LastAddr) begin
                  state_d = StDone;
               end else begin
                  cnt_d   = cnt_q + ADDR_W'(1);
                  state_d = StRead;
               end
            end
         end
         StDone: begin
            if (!i_enable) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         leds_q    <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         leds_q    <= leds_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // A paused write must not reach the RAM, so we follows the switch within WRITE.
   assign o_ram_we    = (state_q == StWrite) && i_enable;
   assign o_ram_addr  = (state_q == StIdle) ? '0 : cnt_q;
   assign o_ram_wdata = (state_q == StWrite) ? pat : '0;
   assign o_leds      = leds_q;
   assign o_done      = (state_q == StDone);
   assign o_err_cnt   = err_cnt_q;

   always_comb begin
      o_led_r           = '0;
      o_led_r[LedWrite] = (state_q == StWrite);
      o_led_r[LedRead]  = (state_q == StRead) || (state_q == StCheck) || (state_q == StHold);
      o_led_r[LedDone]  = o_done;
      o_led_r[LedErr]   = err_q;
   end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a behavioural 1-cycle-latency RAM per DUT instance.
module tb_ram_seq_ctrl;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // DUT A: ADDR_W=2, TICK_DIV=4
   logic       a_reset, a_enable, a_we, a_done;
   logic [1:0] a_addr;
   logic [7:0] a_wdata, a_rdata;
   logic [3:0] a_leds, a_led_r;
   logic [2:0] a_err;
   logic       fault_a;
   logic [7:0] mem_a [4];
   int         wr_log [256];
   int         wr_n = 0;

   // DUT B: ADDR_W=4, TICK_DIV=1
   logic       b_reset, b_enable, b_we, b_done;
   logic [3:0] b_addr;
   logic [7:0] b_wdata, b_rdata;
   logic [3:0] b_leds, b_led_r;
   logic [4:0] b_err;
   logic [7:0] mem_b [16];

   ram_seq_ctrl #(.ADDR_W(2), .DATA_W(8), .SEED(32'hA5), .TICK_DIV(4)) u_dut_a (
      .clock(clock), .i_reset(a_reset), .i_enable(a_enable), .o_ram_we(a_we),
      .o_ram_addr(a_addr), .o_ram_wdata(a_wdata), .i_ram_rdata(a_rdata), .o_leds(a_leds),
      .o_led_r(a_led_r), .o_done(a_done), .o_err_cnt(a_err)
   );

   ram_seq_ctrl #(.ADDR_W(4), .DATA_W(8), .SEED(32'hA5), .TICK_DIV(1)) u_dut_b (
      .clock(clock), .i_reset(b_reset), .i_enable(b_enable), .o_ram_we(b_we),
      .o_ram_addr(b_addr), .o_ram_wdata(b_wdata), .i_ram_rdata(b_rdata), .o_leds(b_leds),
      .o_led_r(b_led_r), .o_done(b_done), .o_err_cnt(b_err)
   );

   always @(posedge clock) begin
      if (a_we) begin
         mem_a[a_addr]  <= a_wdata;
         wr_log[wr_n]   <= int'(a_addr);
         wr_n           <= wr_n + 1;
      end
      a_rdata <= (fault_a && a_addr == 2'd2) ? 8'h00 : mem_a[a_addr];
   end

   always @(posedge clock) begin
      if (b_we) mem_b[b_addr] <= b_wdata;
      b_rdata <= mem_b[b_addr];
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int wr_base = 0;
   logic [3:0] leds_log [$];
   logic [3:0] leds_prev;
   logic [7:0] exp_pat  [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
   logic [3:0] exp_leds [4] = '{4'h5, 4'h4, 4'h7, 4'h6};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      cyc++;
      if (a_leds != leds_prev) begin
         leds_log.push_back(a_leds);
         leds_prev = a_leds;
      end
   endtask

   task automatic mark_run();
      leds_log.delete();
      leds_prev = a_leds;
      wr_base   = wr_n;
      t0        = cyc;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_we"}, a_we, 0);
      chk({tag, "_addr"}, a_addr, 0);
      chk({tag, "_wdata"}, a_wdata, 0);
      chk({tag, "_leds"}, a_leds, 0);
      chk({tag, "_led_r"}, a_led_r, 0);
      chk({tag, "_done"}, a_done, 0);
      chk({tag, "_err"}, a_err, 0);
   endtask

   task automatic wait_done(output int lat);
      for (int i = 0; i < 200 && !a_done; i++) step();
      chk("done_seen", a_done, 1);
      lat = cyc - t0;
   endtask

   task automatic check_run(input string tag, input int exp_lat, input logic [3:0] led2,
                            input logic [2:0] exp_err, input logic [3:0] exp_ledr);
      int lat;
      wait_done(lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_nleds"}, leds_log.size(), 4);
      for (int k = 0; k < 4 && k < leds_log.size(); k++)
         chk({tag, "_leds"}, leds_log[k], (k == 2) ? led2 : exp_leds[k]);
      chk({tag, "_nwr"}, wr_n - wr_base, 4);
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_wr_addr"}, wr_log[wr_base + k], k);
         chk({tag, "_mem"}, mem_a[k], exp_pat[k]);
      end
      chk({tag, "_err"}, a_err, exp_err);
      chk({tag, "_led_r"}, a_led_r, exp_ledr);
      chk({tag, "_addr_done"}, a_addr, 3);
   endtask

   initial begin
      int lat;
      a_reset = 1'b1; a_enable = 1'b0; fault_a = 1'b0;
      b_reset = 1'b1; b_enable = 1'b0;
      leds_prev = 4'h0;
      step(); step();
      chk_zero("reset");
      a_reset = 1'b0;
      step();
      chk_zero("idle");

      // Basic run
      mark_run();
      a_enable = 1'b1;
      check_run("basic", 29, 4'h7, 3'd0, 4'b0100);

      // Pause mid-WRITE and mid-HOLD
      a_enable = 1'b0;
      step();
      chk("back_idle_done", a_done, 0);
      mark_run();
      a_enable = 1'b1;
      for (int i = 0; i < 20 && !(a_led_r[0] && a_addr == 2'd2); i++) step();
      chk("pw_reached", a_addr, 2);
      a_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("pw_we", a_we, 0);
         chk("pw_addr", a_addr, 2);
      end
      a_enable = 1'b1;
      for (int i = 0; i < 40 && a_leds != 4'h4; i++) step();
      chk("ph_reached", a_leds, 4'h4);
      a_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("ph_addr", a_addr, 1);
         chk("ph_led_r", a_led_r, 4'b0010);
      end
      a_enable = 1'b1;
      check_run("pause", 39, 4'h7, 3'd0, 4'b0100);

      // Fault injection on addr 2
      a_enable = 1'b0;
      step();
      mark_run();
      fault_a  = 1'b1;
      a_enable = 1'b1;
      for (int i = 0; i < 40 && a_leds != 4'h4; i++) step();
      chk("flt_err_before", a_led_r[3], 0);
      for (int i = 0; i < 20 && !a_led_r[3]; i++) step();
      chk("flt_err_set", a_led_r[3], 1);
      chk("flt_leds_held", a_leds, 4'h0);
      chk("flt_addr", a_addr, 2);
      chk("flt_cnt_mid", a_err, 1);
      check_run("fault", 29, 4'h0, 3'd1, 4'b1100);

      // Restart: errors persist in IDLE, clear on entering WRITE
      fault_a  = 1'b0;
      a_enable = 1'b0;
      step();
      chk("rs_idle_done", a_done, 0);
      chk("rs_idle_err", a_err, 1);
      chk("rs_idle_led_r", a_led_r, 4'b1000);
      mark_run();
      a_enable = 1'b1;
      step();
      chk("rs_write_err", a_err, 0);
      chk("rs_write_led_r", a_led_r, 4'b0001);
      chk("rs_write_addr", a_addr, 0);
      for (int i = 0; i < 20 && !a_led_r[1]; i++) step();
      chk("rs_read_addr", a_addr, 0);
      chk("rs_read_nwr", wr_n - wr_base, 4);
      check_run("restart", 29, 4'h7, 3'd0, 4'b0100);

      // Reset during HOLD of addr 1
      a_enable = 1'b0;
      step();
      a_enable = 1'b1;
      for (int i = 0; i < 40 && a_leds != 4'h4; i++) step();
      chk("rst_reached", a_leds, 4'h4);
      step();
      a_reset = 1'b1;
      step();
      chk_zero("rst_mid");
      mark_run();
      a_reset = 1'b0;
      check_run("rst_rerun", 29, 4'h7, 3'd0, 4'b0100);

      // Full depth on DUT B
      @(negedge clock);
      b_reset = 1'b0;
      @(negedge clock);
      chk("b_idle_done", b_done, 0);
      b_enable = 1'b1;
      lat = 0;
      for (int i = 0; i < 200 && !b_done; i++) begin
         @(negedge clock);
         lat++;
      end
      chk("b_lat", lat, 65);
      chk("b_err", b_err, 0);
      chk("b_leds", b_leds, 4'hA);
      chk("b_led_r", b_led_r, 4'b0100);
      for (int k = 0; k < 16; k++) chk("b_mem", mem_b[k], 8'hA5 ^ 8'(k));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
